// File: rtl/ot_pingpong_ctrl_if.sv
// Bundle of FIFO, dual SRAM bank and drain-stream signals for the ping-pong output tile controller.
// The controller owns the master side; the FIFO, SRAM banks and downstream consumer sit on the slave side.
interface ot_pingpong_ctrl_if #(
   parameter int SRAM_ADDR_BITS = 10,
   parameter int SRAM_DATA_BITS = 64
);
   logic                      fifo_empty_n;
   logic [SRAM_DATA_BITS-1:0] fifo_data;
   logic                      fifo_read;
   logic                      cen0;
   logic                      cen1;
   logic                      wen0;
   logic                      wen1;
   logic [SRAM_ADDR_BITS-1:0] addr0;
   logic [SRAM_ADDR_BITS-1:0] addr1;
   logic [SRAM_DATA_BITS-1:0] wdata0;
   logic [SRAM_DATA_BITS-1:0] wdata1;
   logic [SRAM_DATA_BITS-1:0] rdata0;
   logic [SRAM_DATA_BITS-1:0] rdata1;
   logic                      dout_valid;
   logic [SRAM_DATA_BITS-1:0] dout_data;
   logic                      dout_ready;
   logic                      dout_last;
   logic [1:0]                bank_full;

   modport master (
      input  fifo_empty_n, fifo_data, rdata0, rdata1, dout_ready,
      output fifo_read, cen0, cen1, wen0, wen1, addr0, addr1, wdata0, wdata1,
             dout_valid, dout_data, dout_last, bank_full
   );

   modport slave (
      output fifo_empty_n, fifo_data, rdata0, rdata1, dout_ready,
      input  fifo_read, cen0, cen1, wen0, wen1, addr0, addr1, wdata0, wdata1,
             dout_valid, dout_data, dout_last, bank_full
   );
endinterface

// File: rtl/ot_pingpong_ctrl.sv
// Ping-pong output tile controller: fills two SRAM banks alternately from a FWFT FIFO
// and drains each full bank word by word onto a valid/ready stream.
module ot_pingpong_ctrl #(
   parameter int ADDR_FINAL     = 20,
   parameter int SRAM_ADDR_BITS = 10,
   parameter int SRAM_DATA_BITS = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   ot_pingpong_ctrl_if.master   bus
);

   localparam logic [SRAM_ADDR_BITS-1:0] LAST_ADDR = SRAM_ADDR_BITS'(ADDR_FINAL - 1);

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_CAP, R_OUT} rd_state_t;

   logic                      pop_bank;
   logic [SRAM_ADDR_BITS-1:0] pop_cnt;
   logic                      wr_valid;
   logic                      wr_bank;
   logic [SRAM_ADDR_BITS-1:0] wr_addr;
   logic [SRAM_DATA_BITS-1:0] wr_data;
   logic [1:0]                bank_full;
   logic [1:0]                set_full;
   logic [1:0]                clr_full;
   logic [1:0]                blocked;
   logic                      pop;
   rd_state_t                 state;
   rd_state_t                 state_nxt;
   logic                      rd_bank;
   logic [SRAM_ADDR_BITS-1:0] rd_cnt;
   logic [SRAM_DATA_BITS-1:0] dout_data_q;
   logic                      fetch;
   logic                      capture;
   logic                      drain_hs;

   // A bank whose final write is committing this cycle counts as full already,
   // so the filler can never slip an extra word into it.
   always_comb begin
      set_full = 2'b00;
      if (wr_valid && (wr_addr == LAST_ADDR)) begin
         set_full[wr_bank] = 1'b1;
      end
      blocked = bank_full | set_full;
      pop     = reset & bus.fifo_empty_n & ~blocked[pop_bank];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pop_bank <= 1'b0;
         pop_cnt  <= '0;
         wr_valid <= 1'b0;
         wr_bank  <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_valid <= pop;
         if (pop) begin
            wr_bank <= pop_bank;
            wr_addr <= pop_cnt;
            wr_data <= bus.fifo_data;
            if (pop_cnt == LAST_ADDR) begin
               pop_cnt  <= '0;
               pop_bank <= ~pop_bank;
            end else begin
               pop_cnt <= pop_cnt + SRAM_ADDR_BITS'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= R_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      fetch     = 1'b0;
      capture   = 1'b0;
      drain_hs  = 1'b0;
      clr_full  = 2'b00;
      case (state)
         R_IDLE: begin
            if (bank_full[rd_bank]) begin
               state_nxt = R_FETCH;
            end
         end
         R_FETCH: begin
            fetch     = 1'b1;
            state_nxt = R_CAP;
         end
         R_CAP: begin
            capture   = 1'b1;
            state_nxt = R_OUT;
         end
         R_OUT: begin
            if (bus.dout_ready) begin
               drain_hs = 1'b1;
               if (rd_cnt == LAST_ADDR) begin
                  clr_full[rd_bank] = 1'b1;
                  state_nxt         = R_IDLE;
               end else begin
                  state_nxt = R_FETCH;
               end
            end
         end
         default: state_nxt = R_IDLE;
      endcase
   end

   // Set and clear target different banks, so both apply in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bank_full   <= 2'b00;
         rd_bank     <= 1'b0;
         rd_cnt      <= '0;
         dout_data_q <= '0;
      end else begin
         bank_full <= (bank_full & ~clr_full) | set_full;
         if (capture) begin
            dout_data_q <= rd_bank ? bus.rdata1 : bus.rdata0;
         end
         if (drain_hs) begin
            if (rd_cnt == LAST_ADDR) begin
               rd_cnt  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + SRAM_ADDR_BITS'(1);
            end
         end
      end
   end

   always_comb begin
      bus.cen0   = 1'b1;
      bus.wen0   = 1'b1;
      bus.addr0  = '0;
      bus.wdata0 = '0;
      bus.cen1   = 1'b1;
      bus.wen1   = 1'b1;
      bus.addr1  = '0;
      bus.wdata1 = '0;
      if (wr_valid) begin
         if (!wr_bank) begin
            bus.cen0   = 1'b0;
            bus.wen0   = 1'b0;
            bus.addr0  = wr_addr;
            bus.wdata0 = wr_data;
         end else begin
            bus.cen1   = 1'b0;
            bus.wen1   = 1'b0;
            bus.addr1  = wr_addr;
            bus.wdata1 = wr_data;
         end
      end
      if (fetch) begin
         if (!rd_bank) begin
            bus.cen0  = 1'b0;
            bus.addr0 = rd_cnt;
         end else begin
            bus.cen1  = 1'b0;
            bus.addr1 = rd_cnt;
         end
      end
   end

   assign bus.fifo_read  = pop;
   assign bus.dout_valid = (state == R_OUT);
   assign bus.dout_last  = (state == R_OUT) && (rd_cnt == LAST_ADDR);
   assign bus.dout_data  = dout_data_q;
   assign bus.bank_full  = bank_full;

endmodule

// File: tb/tb_ot_pingpong_ctrl.sv
// Self-checking bench for ot_pingpong_ctrl with ADDR_FINAL=4: FIFO and SRAM models around the DUT
// and a scoreboard built on word/tile counts rather than the controller's internals.
module tb_ot_pingpong_ctrl;

   localparam int AF = 4;
   localparam int AB = 10;
   localparam int DB = 64;

   logic clk;
   logic reset;

   ot_pingpong_ctrl_if #(.SRAM_ADDR_BITS(AB), .SRAM_DATA_BITS(DB)) bus ();

   ot_pingpong_ctrl #(.ADDR_FINAL(AF), .SRAM_ADDR_BITS(AB), .SRAM_DATA_BITS(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int passes = 0;

   logic [DB-1:0] fifoQ[$];
   logic [DB-1:0] expOut[$];
   logic [DB-1:0] seen[$];
   logic          seenLast[$];
   logic [DB-1:0] mem0 [0:(1<<AB)-1];
   logic [DB-1:0] mem1 [0:(1<<AB)-1];
   bit            fifoEnable, fifoRandom;
   int            readyMode;
   int            popCount, writeCount, drainCount;
   bit            pendWrite;
   logic [DB-1:0] pendWord;
   int            pendIdx;
   bit            prevStall;
   logic [DB-1:0] prevData;
   bit            rdHit0, rdHit1;
   logic [DB-1:0] rdVal0, rdVal1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time exhausted, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic resetModel();
      expOut.delete();
      seen.delete();
      seenLast.delete();
      popCount   = 0;
      writeCount = 0;
      drainCount = 0;
      pendWrite  = 0;
      prevStall  = 0;
      rdHit0     = 0;
      rdHit1     = 0;
   endtask

   task automatic driveInputs();
      bit gate;
      gate = fifoRandom ? bit'($urandom_range(0, 1)) : 1'b1;
      bus.rdata0       = rdHit0 ? rdVal0 : {$urandom, $urandom};
      bus.rdata1       = rdHit1 ? rdVal1 : {$urandom, $urandom};
      bus.fifo_empty_n = fifoEnable && gate && (fifoQ.size() > 0);
      bus.fifo_data    = (fifoQ.size() > 0) ? fifoQ[0] : '0;
      case (readyMode)
         0:       bus.dout_ready = 1'b0;
         1:       bus.dout_ready = 1'b1;
         2:       bus.dout_ready = ~bus.dout_ready;
         default: bus.dout_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // One clock of environment: scoreboard at the falling edge, then SRAM/FIFO effects of the rising edge.
   task automatic cycle();
      logic [1:0] fullExp, wrMask, rdMask, expMask;
      int         tilesFull, tilesDrained;
      logic       expRead, expLast;
      @(negedge clk);
      rdHit0 = 0;
      rdHit1 = 0;
      if (reset) begin
         tilesFull    = writeCount / AF;
         tilesDrained = drainCount / AF;
         fullExp      = 2'b00;
         for (int k = tilesDrained; k < tilesFull; k++) fullExp[k % 2] = 1'b1;
         checks++;
         if (bus.bank_full !== fullExp) $display("[TB] FAIL bank_full: got %b expected %b", bus.bank_full, fullExp);
         else passes++;
         expRead = bus.fifo_empty_n && !fullExp[(popCount / AF) % 2];
         checks++;
         if (bus.fifo_read !== expRead) $display("[TB] FAIL fifo_read: got %b expected %b", bus.fifo_read, expRead);
         else passes++;
         wrMask  = {!bus.cen1 && !bus.wen1, !bus.cen0 && !bus.wen0};
         rdMask  = {!bus.cen1 && bus.wen1, !bus.cen0 && bus.wen0};
         expMask = 2'b00;
         if (pendWrite) expMask[(pendIdx / AF) % 2] = 1'b1;
         checks++;
         if (wrMask !== expMask) $display("[TB] FAIL write_bank: got %b expected %b", wrMask, expMask);
         else passes++;
         if (pendWrite && (wrMask === expMask)) begin
            checks++;
            if ((expMask[0] ? bus.addr0 : bus.addr1) !== AB'(pendIdx % AF))
               $display("[TB] FAIL write_addr: got %0d expected %0d", expMask[0] ? bus.addr0 : bus.addr1, pendIdx % AF);
            else passes++;
            checks++;
            if ((expMask[0] ? bus.wdata0 : bus.wdata1) !== pendWord)
               $display("[TB] FAIL write_data: got %h expected %h", expMask[0] ? bus.wdata0 : bus.wdata1, pendWord);
            else passes++;
         end
         checks++;
         if ((wrMask & bus.bank_full) !== 2'b00) $display("[TB] FAIL write_to_full: got %b expected 00", wrMask & bus.bank_full);
         else passes++;
         if (rdMask !== 2'b00) begin
            expMask = 2'b00;
            expMask[(drainCount / AF) % 2] = 1'b1;
            checks++;
            if (rdMask !== expMask) $display("[TB] FAIL read_bank: got %b expected %b", rdMask, expMask);
            else passes++;
            if (rdMask === expMask) begin
               checks++;
               if ((rdMask[0] ? bus.addr0 : bus.addr1) !== AB'(drainCount % AF))
                  $display("[TB] FAIL read_addr: got %0d expected %0d", rdMask[0] ? bus.addr0 : bus.addr1, drainCount % AF);
               else passes++;
            end
         end
         if (prevStall) begin
            checks++;
            if ({bus.dout_valid, bus.dout_data} !== {1'b1, prevData})
               $display("[TB] FAIL dout_hold: got %b/%h expected 1/%h", bus.dout_valid, bus.dout_data, prevData);
            else passes++;
         end
         if (bus.dout_valid && bus.dout_ready) begin
            expLast = ((drainCount % AF) == AF - 1);
            checks++;
            if (expOut.size() == 0) $display("[TB] FAIL dout_extra: got %h expected no word", bus.dout_data);
            else if ({bus.dout_data, bus.dout_last} !== {expOut[0], expLast})
               $display("[TB] FAIL dout_word: got %h/%b expected %h/%b", bus.dout_data, bus.dout_last, expOut[0], expLast);
            else passes++;
            if (expOut.size() > 0) void'(expOut.pop_front());
            seen.push_back(bus.dout_data);
            seenLast.push_back(bus.dout_last);
            drainCount++;
         end
         prevStall = bus.dout_valid && !bus.dout_ready;
         prevData  = bus.dout_data;
         if (pendWrite) writeCount++;
         if (wrMask[0]) mem0[bus.addr0] = bus.wdata0;
         if (wrMask[1]) mem1[bus.addr1] = bus.wdata1;
         if (rdMask[0]) begin rdHit0 = 1; rdVal0 = mem0[bus.addr0]; end
         if (rdMask[1]) begin rdHit1 = 1; rdVal1 = mem1[bus.addr1]; end
         pendWrite = 0;
         if (bus.fifo_read && fifoQ.size() > 0) begin
            pendWord  = fifoQ.pop_front();
            pendWrite = 1;
            pendIdx   = popCount;
            popCount++;
            expOut.push_back(pendWord);
         end
      end else begin
         pendWrite = 0;
         prevStall = 0;
      end
      @(posedge clk);
      #1;
      driveInputs();
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b0;
      fifoQ.delete();
      fifoEnable = 0;
      fifoRandom = 0;
      resetModel();
      driveInputs();
      repeat (2) cycle();
      reset = 1'b1;
      cycle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      resetModel();
      fifoQ.push_back(64'd100);
      fifoQ.push_back(64'd101);
      fifoEnable = 1;
      readyMode  = 1;
      driveInputs();
      repeat (2) cycle();
      checks++;
      if ({bus.fifo_read, bus.cen1, bus.cen0, bus.wen1, bus.wen0} !== 5'b0_11_11)
         $display("[TB] FAIL reset_ctrl: got %b expected 01111", {bus.fifo_read, bus.cen1, bus.cen0, bus.wen1, bus.wen0});
      else passes++;
      checks++;
      if ({bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} !== '0)
         $display("[TB] FAIL reset_bus: got %h/%h/%h/%h expected 0", bus.addr0, bus.addr1, bus.wdata0, bus.wdata1);
      else passes++;
      checks++;
      if ({bus.dout_valid, bus.dout_last, bus.bank_full, bus.dout_data} !== '0)
         $display("[TB] FAIL reset_dout: got %b/%b/%b/%h expected 0", bus.dout_valid, bus.dout_last, bus.bank_full, bus.dout_data);
      else passes++;
      fifoQ.delete();
      fifoEnable = 0;
      driveInputs();
      reset = 1'b1;
      repeat (6) cycle();
      checks++;
      if ({bus.dout_valid, bus.bank_full, bus.fifo_read} !== 4'b0)
         $display("[TB] FAIL idle_after_reset: got %b expected 0000", {bus.dout_valid, bus.bank_full, bus.fifo_read});
      else passes++;
   endtask

   task automatic test_streaming();
      int n;
      applyReset();
      readyMode = 1;
      for (int i = 1; i <= 8; i++) fifoQ.push_back(DB'(i));
      fifoEnable = 1;
      n = 0;
      while (drainCount < 8 && n < 120) begin cycle(); n++; end
      checks++;
      if (drainCount !== 8) $display("[TB] FAIL stream_drain: got %0d expected 8", drainCount);
      else passes++;
      for (int i = 0; i < AF; i++) begin
         checks++;
         if (mem0[i] !== DB'(i + 1)) $display("[TB] FAIL stream_bank0[%0d]: got %h expected %h", i, mem0[i], i + 1);
         else passes++;
         checks++;
         if (mem1[i] !== DB'(i + 5)) $display("[TB] FAIL stream_bank1[%0d]: got %h expected %h", i, mem1[i], i + 5);
         else passes++;
      end
      for (int i = 0; i < 8 && i < seen.size(); i++) begin
         checks++;
         if ({seen[i], seenLast[i]} !== {DB'(i + 1), (i == 3) || (i == 7)})
            $display("[TB] FAIL stream_out[%0d]: got %h/%b expected %h/%b", i, seen[i], seenLast[i], i + 1, (i == 3) || (i == 7));
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      int n;
      applyReset();
      readyMode = 0;
      for (int i = 1; i <= 12; i++) fifoQ.push_back(DB'(i));
      fifoEnable = 1;
      driveInputs();
      repeat (30) cycle();
      checks++;
      if ({bus.bank_full, bus.fifo_read} !== 3'b11_0)
         $display("[TB] FAIL bp_full: got %b/%b expected 11/0", bus.bank_full, bus.fifo_read);
      else passes++;
      checks++;
      if (popCount !== 8) $display("[TB] FAIL bp_pops: got %0d expected 8", popCount);
      else passes++;
      checks++;
      if ({bus.dout_valid, bus.dout_data} !== {1'b1, DB'(1)})
         $display("[TB] FAIL bp_hold: got %b/%h expected 1/1", bus.dout_valid, bus.dout_data);
      else passes++;
      repeat (5) cycle();
      checks++;
      if (bus.dout_data !== DB'(1)) $display("[TB] FAIL bp_stable: got %h expected 1", bus.dout_data);
      else passes++;
      readyMode = 1;
      n = 0;
      while (bus.bank_full[0] && n < 40) begin cycle(); n++; end
      checks++;
      if (bus.bank_full[0] !== 1'b0) $display("[TB] FAIL bp_clear: got %b expected 0", bus.bank_full[0]);
      else passes++;
      n = 0;
      while (popCount < 9 && n < 40) begin cycle(); n++; end
      repeat (2) cycle();
      checks++;
      if (mem0[0] !== DB'(9)) $display("[TB] FAIL bp_resume: got %h expected 9", mem0[0]);
      else passes++;
      n = 0;
      while (drainCount < 12 && n < 200) begin cycle(); n++; end
      checks++;
      if (drainCount !== 12) $display("[TB] FAIL bp_drain: got %0d expected 12", drainCount);
      else passes++;
   endtask

   task automatic test_toggle_ready();
      int n;
      logic [DB-1:0] sent[$];
      applyReset();
      readyMode = 2;
      for (int i = 0; i < 16; i++) begin
         sent.push_back({$urandom, $urandom});
         fifoQ.push_back(sent[i]);
      end
      fifoEnable = 1;
      n = 0;
      while (drainCount < 16 && n < 400) begin cycle(); n++; end
      checks++;
      if (seen.size() !== 16) $display("[TB] FAIL toggle_count: got %0d expected 16", seen.size());
      else passes++;
      checks++;
      if (seen != sent) $display("[TB] FAIL toggle_order: got first %h expected first %h", seen.size() ? seen[0] : '0, sent[0]);
      else passes++;
   endtask

   task automatic test_random();
      int n;
      applyReset();
      readyMode  = 3;
      fifoRandom = 1;
      for (int i = 0; i < 40; i++) fifoQ.push_back({$urandom, $urandom});
      fifoEnable = 1;
      n = 0;
      while (drainCount < 40 && n < 1500) begin cycle(); n++; end
      checks++;
      if (drainCount !== 40) $display("[TB] FAIL random_drain: got %0d expected 40", drainCount);
      else passes++;
      fifoRandom = 0;
   endtask

   task automatic test_mid_tile_reset();
      int n;
      logic [DB-1:0] third;
      applyReset();
      readyMode = 1;
      for (int i = 0; i < 6; i++) fifoQ.push_back(DB'(32'hA0 + i));
      third = DB'(32'hA2);
      fifoEnable = 1;
      n = 0;
      while (popCount < 2 && n < 20) begin cycle(); n++; end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.fifo_read, bus.cen1, bus.cen0, bus.wen1, bus.wen0, bus.dout_valid, bus.dout_last, bus.bank_full} !== 9'b0_11_11_0_0_00)
         $display("[TB] FAIL midreset_ctrl: got %b expected 011110000",
                  {bus.fifo_read, bus.cen1, bus.cen0, bus.wen1, bus.wen0, bus.dout_valid, bus.dout_last, bus.bank_full});
      else passes++;
      checks++;
      if ({bus.addr0, bus.addr1, bus.wdata0, bus.wdata1, bus.dout_data} !== '0)
         $display("[TB] FAIL midreset_bus: got %h/%h/%h/%h/%h expected 0", bus.addr0, bus.addr1, bus.wdata0, bus.wdata1, bus.dout_data);
      else passes++;
      resetModel();
      repeat (2) cycle();
      reset = 1'b1;
      n = 0;
      while (drainCount < 4 && n < 60) begin cycle(); n++; end
      checks++;
      if ({drainCount == 4, mem0[0]} !== {1'b1, third})
         $display("[TB] FAIL midreset_restart: got %0d/%h expected 4/%h", drainCount, mem0[0], third);
      else passes++;
   endtask

   initial begin
      reset      = 1'b0;
      fifoEnable = 0;
      fifoRandom = 0;
      readyMode  = 0;
      bus.dout_ready = 1'b0;
      resetModel();
      driveInputs();
      test_reset();
      test_streaming();
      test_backpressure();
      test_toggle_ready();
      test_random();
      test_mid_tile_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ot_pingpong_ctrl.md
OT_PINGPONG_CTRL -- requirements
Module: ot_pingpong_ctrl

Interface
REQ-001 SHALL have parameter ADDR_FINAL, default 20, words per output tile per bank.
REQ-002 SHALL have parameter SRAM_ADDR_BITS, default 10, bank address width.
REQ-003 SHALL have parameter SRAM_DATA_BITS, default 64, word width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port fifo_empty_n  input  1  output FIFO holds data; head word is on fifo_data (first-word-fall-through).
REQ-007 SHALL have port fifo_data  input  SRAM_DATA_BITS  FIFO head word.
REQ-008 SHALL have port fifo_read  output  1  pop strobe.
REQ-009 SHALL have ports cen0/cen1  output  1  bank chip enables, active-low.
REQ-010 SHALL have ports wen0/wen1  output  1  bank write enables, active-low.
REQ-011 SHALL have ports addr0/addr1  output  SRAM_ADDR_BITS  bank addresses.
REQ-012 SHALL have ports wdata0/wdata1  output  SRAM_DATA_BITS  bank write data.
REQ-013 SHALL have ports rdata0/rdata1  input  SRAM_DATA_BITS  bank read data, valid one cycle after a read enable.
REQ-014 SHALL have port dout_valid  output  1  drain word valid.
REQ-015 SHALL have port dout_data  output  SRAM_DATA_BITS  drain word, registered.
REQ-016 SHALL have port dout_ready  input  1  downstream accepts drain word.
REQ-017 SHALL have port dout_last  output  1  high with dout_valid on word ADDR_FINAL-1 of a tile.
REQ-018 SHALL have port bank_full  output  2  per-bank full flags.

Function
REQ-019 Fill side: pop_bank bit and pop_cnt counter SHALL be kept; fifo_read = fifo_empty_n & ~bank_full[pop_bank], combinational.
REQ-020 On each pop, fifo_data, pop_bank and pop_cnt SHALL be registered; next cycle the selected bank SHALL see cen=0, wen=0, addr=registered pop_cnt, wdata=registered data (write latency 1).
REQ-021 On a pop with pop_cnt==ADDR_FINAL-1: pop_cnt SHALL wrap to 0 and pop_bank SHALL toggle; otherwise pop_cnt increments.
REQ-022 bank_full[b] SHALL set in the cycle after the write of address ADDR_FINAL-1 to bank b commits.
REQ-023 A pop into a bank SHALL NOT occur while that bank is full or pending set; pops into the other bank SHALL continue back-to-back across the wrap.
REQ-024 Drain FSM states: R_IDLE, R_FETCH, R_CAP, R_OUT; rd_bank bit and rd_cnt counter.
REQ-025 R_IDLE -> R_FETCH when bank_full[rd_bank]; R_FETCH drives cen=0, wen=1, addr=rd_cnt to rd_bank, -> R_CAP.
REQ-026 R_CAP SHALL capture rdata of rd_bank into dout_data, -> R_OUT.
REQ-027 R_OUT: dout_valid=1, dout_data held stable until dout_ready; on handshake, if rd_cnt==ADDR_FINAL-1: clear bank_full[rd_bank], toggle rd_bank, rd_cnt=0, -> R_IDLE; else rd_cnt+1, -> R_FETCH.
REQ-028 Writer accesses only non-full banks, reader only full banks; one bank SHALL never receive both in one cycle.
REQ-029 Idle bank: cen=1, wen=1, addr=0, wdata=0.
REQ-030 Set of bank_full[a] and clear of bank_full[b] in the same cycle SHALL both take effect.
REQ-031 Counters SHALL compare against ADDR_FINAL-1 only; no other wrap value.

Reset
REQ-032 reset low SHALL asynchronously clear pop_bank, pop_cnt, write pipeline, rd_bank, rd_cnt, bank_full; FSM -> R_IDLE.
REQ-033 Under reset: fifo_read=0, cen*=1, wen*=1, addr*=0, wdata*=0, dout_valid=0, dout_data=0, dout_last=0.
REQ-034 Reset mid-tile SHALL discard partial data; first post-reset pop SHALL write bank 0 address 0.

Verification (ADDR_FINAL=4)
REQ-035 FIFO always non-empty, dout_ready=1, words 1..8 -> bank0 addr0..3 = 1..4, bank1 addr0..3 = 5..8; dout sequence 1..8, dout_last on 4 and 8.
REQ-036 dout_ready=0, 12 words offered -> both banks fill, bank_full=2'b11, fifo_read held 0 after 8 pops; dout_valid=1 with dout_data=1 held stable.
REQ-037 Release dout_ready after REQ-036 -> bank0 drained, bank_full[0] clears, popping into bank0 resumes with word 9 at addr0.
REQ-038 dout_ready toggling every cycle -> no duplicated or dropped words; dout_data changes only after handshake.
REQ-039 Reset asserted after 2 pops -> all outputs at reset values next cycle; next tile starts bank0 addr0.
REQ-040 Check every cycle: never cen0=0 with wen0=0 while bank_full[0]=1 (same for bank1).
